logip_capture_ctrl: RTL and testbench
=====================================

// Module: logip_capture_ctrl
//
// PURPOSE
//   Sequences one logic-analyzer capture for logIP.
//   - Arm: write the sample RAM as a ring buffer so pre-trigger history is kept.
//   - Trigger: write a programmed number of post-trigger samples.
//   - Read back: stream a programmed number of samples, newest first, to the UART transmitter.
//   - Sits between the command decoder (arm/abort/config), the trigger unit,
//     the sample-rate divider and the single-port-per-side sample RAM.
//
// PARAMETERS
//   ADDR_W  10  sample RAM address width; depth = 2**ADDR_W
//   CNT_W   16  width of read/delay count config registers
//
// PORTS
//   clk_i        in   1       system clock
//   rst_in       in   1       async active-low reset
//   arm_i        in   1       1-cycle pulse: start capture (honoured only in IDLE)
//   abort_i      in   1       1-cycle pulse: abandon capture, return to IDLE
//   stb_i        in   1       sample strobe from divider; one sample per strobe
//   trg_i        in   1       trigger match, qualified by stb_i
//   read_cnt_i   in   CNT_W   samples to read back
//   delay_cnt_i  in   CNT_W   post-trigger samples to write after the trigger sample
//   we_o         out  1       RAM write enable
//   waddr_o      out  ADDR_W  RAM write address
//   raddr_o      out  ADDR_W  RAM read address (RAM data valid 1 cycle later)
//   rd_valid_o   out  1       read data on RAM output valid for transmitter
//   rd_ready_i   in   1       transmitter accepts current read beat
//   busy_o       out  1       state != IDLE
//   armed_o      out  1       state == ARMED
//   triggered_o  out  1       state == DELAY or READ
//
// BEHAVIOUR
//   Reset values
//   - state=IDLE; all outputs 0; counters 0.
//   Config
//   - read_cnt_i and delay_cnt_i latched on accepted arm_i.
//   - Read count clamped to 2**ADDR_W.
//   FSM: IDLE -> ARMED -> DELAY -> READ -> IDLE
//   - IDLE:  arm_i -> ARMED. waddr is kept, not cleared.
//   - ARMED: each stb_i writes the sample.
//       - stb_i&trg_i, delay==0 -> READ.
//       - stb_i&trg_i, delay!=0 -> DELAY, load dcnt=delay.
//       - The trigger sample itself is always written.
//   - DELAY: each stb_i writes and decrements dcnt. Write with dcnt==1 -> READ.
//   - READ:
//       - Entry: raddr_o = waddr-1 (last written, mod depth); rcnt = clamped read count.
//       - rcnt==0 on entry -> IDLE next cycle; rd_valid_o never asserted.
//       - rd_valid_o rises 1 cycle after raddr_o settles.
//       - Beat accepted when rd_valid_o&rd_ready_i. Next cycle: rd_valid_o=0,
//         raddr_o decrements (wrap mod depth), rcnt decrements.
//       - Following cycle rd_valid_o reasserts. Sustained rate: 1 beat / 2 cycles.
//       - Acceptance of the last beat -> IDLE.
//   Write port
//   - we_o = stb_i & (state==ARMED | state==DELAY), combinational, same cycle as stb_i.
//   - waddr_o increments (mod depth) on the clock edge ending each write.
//   Boundary cases
//   - abort_i has priority over every event, in every state: next state IDLE, no write
//     that cycle, rd_valid_o=0 next cycle.
//   - arm_i outside IDLE is ignored; arm_i+abort_i together -> IDLE.
//   - stb_i with trg_i in the arm_i cycle: not written, since state is still IDLE.
//   - rd_ready_i without rd_valid_o has no effect.
//   - rd_ready_i held high: accepted on every rd_valid_o cycle.
//   - Ring wrap: fewer than read_cnt samples written -> stale RAM words are read; this
//     is legal and not flagged.
//   - Reset mid-capture: immediate IDLE and all outputs 0; RAM contents are undefined
//     to the host.
//
// STRUCTURE
//   - logip_pkg:
//       - ctrl_state_e {IDLE, ARMED, DELAY, READ}
//       - default localparams for ADDR_W and CNT_W
//   - Sub-module logip_down_cnt: loadable CNT_W down-counter with a zero flag, used
//     twice (delay counter, read counter).
//   - Address pointers and FSM live in this module.
//
// TESTING
//   1. ADDR_W=4, delay=3, read=8; arm, 5 stb, then stb+trg, 3 stb
//      -> 9 writes at waddr 0..8; READ from raddr 8 down to 1; 8 beats; IDLE.
//   2. delay=0, read=0; arm, stb+trg
//      -> single write, READ 1 cycle, IDLE; rd_valid_o never high.
//   3. ADDR_W=4, read=40
//      -> clamped to 16 beats; raddr wraps 0 -> 15 mid-stream.
//   4. abort_i during DELAY coincident with stb_i
//      -> no write that cycle; busy_o=0 next cycle; a new arm is accepted.
//   5. rd_ready_i toggled randomly in READ
//      -> exactly read_cnt accepted beats, strictly decreasing raddr, no duplicate
//         or skipped address.
//   6. rst_in asserted in READ with rd_valid_o=1
//      -> all outputs 0 asynchronously; after release, arm works from waddr=0.

Source files
------------

// File: rtl/logip_pkg.sv
// rtl/logip_pkg.sv - shared types and defaults for the logIP capture controller
//
// Purpose: controller state encoding and default widths, imported by the
// capture controller and its down-counter.
// Ports: none (package).
package logip_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DELAY = 2'd2,
    READ  = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/logip_down_cnt.sv
// rtl/logip_down_cnt.sv - loadable down-counter with zero and one flags
//
// Purpose: CNT_W down-counter; load wins over decrement, decrement saturates at 0.
// Ports:
//   clk_i, rst_in  clock, async active-low reset
//   load_i         load load_val_i
//   load_val_i     value to load
//   dec_i          decrement by one
//   zero_o         count == 0
//   last_o         count == 1
module logip_down_cnt
  import logip_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_in,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o,
  output logic             last_o
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);
  assign last_o = (cnt_q == ONE);

endmodule

// File: rtl/logip_capture_ctrl.sv
// rtl/logip_capture_ctrl.sv - logIP capture sequencer: ring-buffer arm, post-trigger delay, newest-first readback
//
// Purpose: writes samples into the sample RAM as a ring while armed, keeps
// writing delay_cnt samples after the trigger, then streams read_cnt samples
// newest first to the UART transmitter with a valid/ready handshake.
// Ports:
//   clk_i, rst_in          clock, async active-low reset
//   arm_i, abort_i         command pulses (abort has priority)
//   stb_i, trg_i           sample strobe, trigger match
//   read_cnt_i             samples to read back (clamped to RAM depth)
//   delay_cnt_i            post-trigger samples after the trigger sample
//   we_o, waddr_o          RAM write port
//   raddr_o                RAM read address (data one cycle later)
//   rd_valid_o, rd_ready_i readback handshake
//   busy_o, armed_o, triggered_o  status
module logip_capture_ctrl
  import logip_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_in,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic              stb_i,
  input  logic              trg_i,
  input  logic [CNT_W-1:0]  read_cnt_i,
  input  logic [CNT_W-1:0]  delay_cnt_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [ADDR_W-1:0] raddr_o,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic              busy_o,
  output logic              armed_o,
  output logic              triggered_o
);
  localparam logic [CNT_W-1:0]  DEPTH    = CNT_W'(2**ADDR_W);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  ctrl_state_e       state_q, state_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0]  rd_cfg_q, rd_cfg_d;
  logic [CNT_W-1:0]  dly_cfg_q, dly_cfg_d;
  logic              we;
  logic              dcnt_load, dcnt_dec, dcnt_zero, dcnt_last;
  logic              rcnt_load, rcnt_dec, rcnt_zero, rcnt_last;

  // Abort wins over the strobe, so an aborting cycle never writes.
  assign we = stb_i & ~abort_i & ((state_q == ARMED) | (state_q == DELAY));

  always_comb begin
    state_d    = state_q;
    waddr_d    = we ? (waddr_q + ADDR_ONE) : waddr_q;
    raddr_d    = raddr_q;
    rd_valid_d = 1'b0;
    rd_cfg_d   = rd_cfg_q;
    dly_cfg_d  = dly_cfg_q;
    dcnt_load  = 1'b0;
    dcnt_dec   = 1'b0;
    rcnt_load  = 1'b0;
    rcnt_dec   = 1'b0;
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (arm_i) begin
            state_d   = ARMED;
            rd_cfg_d  = (read_cnt_i > DEPTH) ? DEPTH : read_cnt_i;
            dly_cfg_d = delay_cnt_i;
          end
        end
        ARMED: begin
          if (stb_i && trg_i) begin
            if (dly_cfg_q == '0) begin
              // The sample written this cycle is the newest one; read starts there.
              state_d   = READ;
              raddr_d   = waddr_q;
              rcnt_load = 1'b1;
            end else begin
              state_d   = DELAY;
              dcnt_load = 1'b1;
            end
          end
        end
        DELAY: begin
          if (stb_i) begin
            dcnt_dec = 1'b1;
            if (dcnt_last || dcnt_zero) begin
              state_d   = READ;
              raddr_d   = waddr_q;
              rcnt_load = 1'b1;
            end
          end
        end
        READ: begin
          if (rcnt_zero) begin
            state_d = IDLE;
          end else if (!rd_valid_q) begin
            // RAM output for raddr_q is ready one cycle after the address.
            rd_valid_d = 1'b1;
          end else if (rd_ready_i) begin
            raddr_d  = raddr_q - ADDR_ONE;
            rcnt_dec = 1'b1;
            if (rcnt_last) begin
              state_d = IDLE;
            end
          end else begin
            rd_valid_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      waddr_q    <= '0;
      raddr_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_cfg_q   <= '0;
      dly_cfg_q  <= '0;
    end else begin
      state_q    <= state_d;
      waddr_q    <= waddr_d;
      raddr_q    <= raddr_d;
      rd_valid_q <= rd_valid_d;
      rd_cfg_q   <= rd_cfg_d;
      dly_cfg_q  <= dly_cfg_d;
    end
  end

  logip_down_cnt #(.CNT_W(CNT_W)) u_dcnt (
    .clk_i      (clk_i),
    .rst_in     (rst_in),
    .load_i     (dcnt_load),
    .load_val_i (dly_cfg_q),
    .dec_i      (dcnt_dec),
    .zero_o     (dcnt_zero),
    .last_o     (dcnt_last)
  );

  logip_down_cnt #(.CNT_W(CNT_W)) u_rcnt (
    .clk_i      (clk_i),
    .rst_in     (rst_in),
    .load_i     (rcnt_load),
    .load_val_i (rd_cfg_q),
    .dec_i      (rcnt_dec),
    .zero_o     (rcnt_zero),
    .last_o     (rcnt_last)
  );

  assign we_o        = we;
  assign waddr_o     = waddr_q;
  assign raddr_o     = raddr_q;
  assign rd_valid_o  = rd_valid_q;
  assign busy_o      = (state_q != IDLE);
  assign armed_o     = (state_q == ARMED);
  assign triggered_o = (state_q == DELAY) || (state_q == READ);

endmodule

// File: tb/tb_logip_capture_ctrl.sv
// tb/tb_logip_capture_ctrl.sv - randomized bench with queue-based capture model for logip_capture_ctrl
module tb_logip_capture_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic        clk;
  logic        rst_n;
  logic        arm, abort, stb, trg, rd_ready;
  logic [15:0] rd_cnt, dly_cnt;
  logic        we, rd_valid, busy, armed, triggered;
  logic [AW-1:0] waddr, raddr;

  logip_capture_ctrl #(.ADDR_W(AW), .CNT_W(16)) dut (
    .clk_i       (clk),
    .rst_in      (rst_n),
    .arm_i       (arm),
    .abort_i     (abort),
    .stb_i       (stb),
    .trg_i       (trg),
    .read_cnt_i  (rd_cnt),
    .delay_cnt_i (dly_cnt),
    .we_o        (we),
    .waddr_o     (waddr),
    .raddr_o     (raddr),
    .rd_valid_o  (rd_valid),
    .rd_ready_i  (rd_ready),
    .busy_o      (busy),
    .armed_o     (armed),
    .triggered_o (triggered)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Capture model: pre-trigger ring, post-trigger countdown, queue of read addresses.
  bit m_waiting_trg, m_post_trg, m_reading, m_valid;
  int m_wptr, m_post_left, m_read, m_delay;
  int m_rq[$];
  int acc_q[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_waiting_trg = 0; m_post_trg = 0; m_reading = 0; m_valid = 0;
    m_wptr = 0; m_post_left = 0; m_read = 0; m_delay = 0;
    m_rq.delete();
  endtask

  task automatic start_read(input int newest);
    int n;
    m_waiting_trg = 0;
    m_post_trg    = 0;
    m_reading     = 1;
    m_valid       = 0;
    n = (m_read > DEPTH) ? DEPTH : m_read;
    m_rq.delete();
    for (int i = 0; i < n; i++) m_rq.push_back((newest - i + 4 * DEPTH) % DEPTH);
  endtask

  task automatic model_update();
    int newest;
    if (abort) begin
      m_waiting_trg = 0; m_post_trg = 0; m_reading = 0; m_valid = 0;
      m_rq.delete();
    end else if (m_reading) begin
      if (m_rq.size() == 0) m_reading = 0;
      else if (!m_valid) m_valid = 1;
      else if (rd_ready) begin
        void'(m_rq.pop_front());
        m_valid = 0;
        if (m_rq.size() == 0) m_reading = 0;
      end
    end else if (m_waiting_trg || m_post_trg) begin
      if (stb) begin
        newest = m_wptr;
        m_wptr = (m_wptr + 1) % DEPTH;
        if (m_waiting_trg) begin
          if (trg) begin
            if (m_delay == 0) start_read(newest);
            else begin
              m_waiting_trg = 0;
              m_post_trg    = 1;
              m_post_left   = m_delay;
            end
          end
        end else begin
          m_post_left--;
          if (m_post_left == 0) start_read(newest);
        end
      end
    end else if (arm) begin
      m_waiting_trg = 1;
      m_read        = int'(rd_cnt);
      m_delay       = int'(dly_cnt);
    end
  endtask

  task automatic compare_now();
    chk("busy_o", int'(busy), int'(m_waiting_trg || m_post_trg || m_reading));
    chk("armed_o", int'(armed), int'(m_waiting_trg));
    chk("triggered_o", int'(triggered), int'(m_post_trg || m_reading));
    chk("we_o", int'(we), int'(stb && !abort && (m_waiting_trg || m_post_trg)));
    chk("waddr_o", int'(waddr), m_wptr);
    chk("rd_valid_o", int'(rd_valid), int'(m_valid));
    if (m_valid && m_rq.size() > 0) chk("raddr_o", int'(raddr), m_rq[0]);
    if (rd_valid && rd_ready) acc_q.push_back(int'(raddr));
  endtask

  // One clock: drive after the edge, compare mid-cycle, advance model at the edge.
  task automatic step(input bit a, input bit ab, input bit s, input bit t, input bit r);
    arm = a; abort = ab; stb = s; trg = t; rd_ready = r;
    @(negedge clk);
    compare_now();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic run_until_idle(input bit always_ready);
    int n;
    n = 0;
    while (busy && n < 300) begin
      step(0, 0, 0, 0, always_ready ? 1'b1 : 1'($urandom_range(0, 1)));
      n++;
    end
    chk("idle_timeout", int'(busy), 0);
  endtask

  int s0, n;
  bit wrap_seen;

  initial begin
    rst_n = 0; arm = 0; abort = 0; stb = 0; trg = 0; rd_ready = 0;
    rd_cnt = '0; dly_cnt = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_we", int'(we), 0);
    chk("rst_waddr", int'(waddr), 0);
    chk("rst_raddr", int'(raddr), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_armed", int'(armed), 0);
    chk("rst_triggered", int'(triggered), 0);
    rst_n = 1;

    // 1: delay 3, read 8; writes 0..8, read 8 down to 1
    rd_cnt = 16'd8; dly_cnt = 16'd3;
    s0 = acc_q.size();
    step(1, 0, 0, 0, 0);
    repeat (5) step(0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 0);
    repeat (3) step(0, 0, 1, 0, 0);
    chk("t1_read_state", int'(triggered && !armed), 1);
    run_until_idle(1);
    chk("t1_beats", acc_q.size() - s0, 8);
    if (acc_q.size() > s0) begin
      chk("t1_first_raddr", acc_q[s0], 8);
      chk("t1_last_raddr", acc_q[acc_q.size() - 1], 1);
    end
    chk("t1_waddr", int'(waddr), 9);

    // 2: delay 0, read 0; one write, one READ cycle, no beats
    rd_cnt = 16'd0; dly_cnt = 16'd0;
    s0 = acc_q.size();
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    chk("t2_in_read", int'(triggered), 1);
    step(0, 0, 0, 0, 1);
    chk("t2_idle", int'(busy), 0);
    chk("t2_beats", acc_q.size() - s0, 0);
    chk("t2_waddr", int'(waddr), 10);

    // 3: read 40 clamps to 16; newest is 12, wraps 0 -> 15
    rd_cnt = 16'd40; dly_cnt = 16'd2;
    s0 = acc_q.size();
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    repeat (2) step(0, 0, 1, 0, 0);
    run_until_idle(0);
    chk("t3_beats", acc_q.size() - s0, 16);
    wrap_seen = 0;
    for (int i = s0 + 1; i < acc_q.size(); i++)
      if (acc_q[i - 1] == 0 && acc_q[i] == 15) wrap_seen = 1;
    chk("t3_wrap", int'(wrap_seen), 1);
    if (acc_q.size() > s0) begin
      chk("t3_first_raddr", acc_q[s0], 12);
      chk("t3_last_raddr", acc_q[acc_q.size() - 1], 13);
    end

    // 4: abort with strobe in DELAY; then re-arm (strobe+trigger in arm cycle not written)
    rd_cnt = 16'd4; dly_cnt = 16'd5;
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    chk("t4_busy_after_abort", int'(busy), 0);
    chk("t4_waddr_after_abort", int'(waddr), 15);
    step(1, 0, 1, 1, 0);
    chk("t4_rearm", int'(armed), 1);
    chk("t4_arm_cycle_no_write", int'(waddr), 15);
    s0 = acc_q.size();
    step(0, 0, 1, 1, 0);
    repeat (5) step(0, 0, 1, 0, 0);
    run_until_idle(0);
    chk("t4_beats", acc_q.size() - s0, 4);
    if (acc_q.size() > s0) begin
      chk("t4_first_raddr", acc_q[s0], 4);
      chk("t4_last_raddr", acc_q[acc_q.size() - 1], 1);
    end

    // 5: random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        rd_cnt  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 40));
        dly_cnt = 16'($urandom_range(0, 6));
      end
      step($urandom_range(0, 19) == 0, $urandom_range(0, 149) == 0,
           1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)));
    end

    // 6: reset while a read beat is valid
    step(0, 1, 0, 0, 0);
    rd_cnt = 16'd4; dly_cnt = 16'd0;
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    n = 0;
    while (!rd_valid && n < 10) begin
      step(0, 0, 0, 0, 0);
      n++;
    end
    chk("t6_valid_before_reset", int'(rd_valid), 1);
    #2;
    rst_n = 0;
    model_reset();
    #1;
    chk("t6_rst_rd_valid", int'(rd_valid), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_triggered", int'(triggered), 0);
    chk("t6_rst_waddr", int'(waddr), 0);
    chk("t6_rst_raddr", int'(raddr), 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    rd_cnt = 16'd1; dly_cnt = 16'd0;
    s0 = acc_q.size();
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    run_until_idle(1);
    chk("t6_beats", acc_q.size() - s0, 1);
    if (acc_q.size() > s0) chk("t6_first_raddr", acc_q[s0], 0);
    chk("t6_waddr", int'(waddr), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
